// File: rtl/game_pkg.sv
// Shared types, constants and small combinational helpers for the door game controller.
package game_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, REVEAL, GAME_OVER} game_state_t;

    localparam logic [1:0] LIVES_MAX   = 2'b11;
    localparam logic [1:0] DOOR_LAST   = 2'd3;
    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // Fibonacci LFSR, taps 16,14,13,11 expressed on a right-shifting register.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [1:0] step_pos(input logic [1:0] pos, input logic left,
                                            input logic right);
        logic [1:0] nxt;
        nxt = pos;
        if (left && !right && pos != 2'd0) begin
            nxt = pos - 2'd1;
        end else if (right && !left && pos != DOOR_LAST) begin
            nxt = pos + 2'd1;
        end
        return nxt;
    endfunction

    function automatic logic [1:0] judge_lives(input logic [1:0] lives, input logic [1:0] pos,
                                               input logic [1:0] d1, input logic [1:0] d2);
        if (pos == d1 || pos == d2 || lives == 2'd0) begin
            return lives;
        end
        return lives - 2'd1;
    endfunction

    // Second door must differ from the first; on a collision bump it by one.
    function automatic logic [1:0] pick_door2(input logic [3:0] bits);
        if (bits[3:2] == bits[1:0]) begin
            return bits[1:0] + 2'd1;
        end
        return bits[3:2];
    endfunction

endpackage

// File: rtl/game_controller_second_ticker.sv
// One-cycle tick every CLK_HZ cycles; clearing restarts the count so the
// first tick lands exactly CLK_HZ cycles after the clear.
module second_ticker #(
    parameter int unsigned CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned      CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/game_controller.sv
// Round/lives state machine for the two-player door game; drives every
// game-state input of the screen drawer from registered state.
module game_controller
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 25_000_000,
    parameter int unsigned ROUND_SECONDS  = 10,
    parameter int unsigned REVEAL_SECONDS = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p2_left,
    input  logic       p2_right,
    output logic [1:0] correct_door_1,
    output logic [1:0] correct_door_2,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic [1:0] player_1_pos,
    output logic [1:0] player_2_pos,
    output logic       resume,
    output logic       time_up,
    output logic [3:0] seconds_left,
    output logic [1:0] winner
);
    localparam logic [3:0] ROUND_SEC  = 4'(ROUND_SECONDS);
    localparam logic [3:0] REVEAL_SEC = 4'(REVEAL_SECONDS);

    game_state_t state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  door1_q, door1_d, door2_q, door2_d;
    logic [1:0]  lives1_q, lives1_d, lives2_q, lives2_d;
    logic [1:0]  pos1_q, pos1_d, pos2_q, pos2_d;
    logic [3:0]  sec_q, sec_d;
    logic [1:0]  winner_q, winner_d;
    logic        resume_q, resume_d;
    logic        time_up_q, time_up_d;
    logic        tick;
    logic        entering;

    assign entering = (state_d != state_q);

    second_ticker #(
        .CLK_HZ(CLK_HZ)
    ) u_ticker (
        .clk  (clk),
        .reset(reset),
        .clear(entering),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_next(lfsr_q);
        door1_d  = door1_q;
        door2_d  = door2_q;
        lives1_d = lives1_q;
        lives2_d = lives2_q;
        pos1_d   = pos1_q;
        pos2_d   = pos2_q;
        sec_d    = sec_q;
        winner_d = winner_q;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d  = ROUND;
                    lives1_d = LIVES_MAX;
                    lives2_d = LIVES_MAX;
                    winner_d = WINNER_NONE;
                end
            end
            ROUND: begin
                if (tick) begin
                    if (sec_q == 4'd1) begin
                        state_d  = REVEAL;
                        sec_d    = 4'd0;
                        lives1_d = judge_lives(lives1_q, pos1_q, door1_q, door2_q);
                        lives2_d = judge_lives(lives2_q, pos2_q, door1_q, door2_q);
                    end else begin
                        sec_d = sec_q - 4'd1;
                    end
                end
                // Moves on the closing edge are dropped so the judged position stays on screen.
                if (state_d == ROUND) begin
                    pos1_d = step_pos(pos1_q, p1_left, p1_right);
                    pos2_d = step_pos(pos2_q, p2_left, p2_right);
                end
            end
            REVEAL: begin
                // seconds_left is 0 only on the first REVEAL cycle; load the reveal countdown then.
                if (sec_q == 4'd0) begin
                    sec_d = REVEAL_SEC;
                end else if (tick) begin
                    if (sec_q == 4'd1) begin
                        if (lives1_q == 2'd0 || lives2_q == 2'd0) begin
                            state_d  = GAME_OVER;
                            sec_d    = 4'd0;
                            winner_d = {lives1_q == 2'd0, lives2_q == 2'd0};
                        end else begin
                            state_d = ROUND;
                        end
                    end else begin
                        sec_d = sec_q - 4'd1;
                    end
                end
            end
            default: ;
        endcase

        if (state_d == ROUND && state_q != ROUND) begin
            pos1_d  = 2'd0;
            pos2_d  = 2'd0;
            sec_d   = ROUND_SEC;
            door1_d = lfsr_q[1:0];
            door2_d = pick_door2(lfsr_q[3:0]);
        end

        resume_d  = (state_d == IDLE) || (state_d == ROUND);
        time_up_d = !resume_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            door1_q   <= 2'd0;
            door2_q   <= 2'd1;
            lives1_q  <= LIVES_MAX;
            lives2_q  <= LIVES_MAX;
            pos1_q    <= 2'd0;
            pos2_q    <= 2'd0;
            sec_q     <= ROUND_SEC;
            winner_q  <= WINNER_NONE;
            resume_q  <= 1'b1;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            door1_q   <= door1_d;
            door2_q   <= door2_d;
            lives1_q  <= lives1_d;
            lives2_q  <= lives2_d;
            pos1_q    <= pos1_d;
            pos2_q    <= pos2_d;
            sec_q     <= sec_d;
            winner_q  <= winner_d;
            resume_q  <= resume_d;
            time_up_q <= time_up_d;
        end
    end

    assign correct_door_1 = door1_q;
    assign correct_door_2 = door2_q;
    assign p1_lives       = lives1_q;
    assign p2_lives       = lives2_q;
    assign player_1_pos   = pos1_q;
    assign player_2_pos   = pos2_q;
    assign resume         = resume_q;
    assign time_up        = time_up_q;
    assign seconds_left   = sec_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus a randomized run against a
// cycle-count based model of the game rules.
`timescale 1ns/1ps
module tb_game_controller;
    localparam int CLK_HZ   = 10;
    localparam int ROUND_S  = 2;
    localparam int REVEAL_S = 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int PH_IDLE = 0, PH_ROUND = 1, PH_REVEAL = 2, PH_OVER = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, p1_left = 1'b0, p1_right = 1'b0, p2_left = 1'b0, p2_right = 1'b0;
    logic [1:0] correct_door_1, correct_door_2, p1_lives, p2_lives, player_1_pos, player_2_pos;
    logic       resume, time_up;
    logic [3:0] seconds_left;
    logic [1:0] winner;

    int n_checks = 0;
    int n_fail   = 0;
    int cycnum   = 0;

    int m_phase, m_cyc, m_l1, m_l2, m_p1, m_p2, m_d1, m_d2, m_win, m_entry;
    logic [15:0] m_lfsr;

    game_controller #(
        .CLK_HZ(CLK_HZ), .ROUND_SECONDS(ROUND_S), .REVEAL_SECONDS(REVEAL_S), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_left(p1_left), .p1_right(p1_right), .p2_left(p2_left), .p2_right(p2_right),
        .correct_door_1(correct_door_1), .correct_door_2(correct_door_2),
        .p1_lives(p1_lives), .p2_lives(p2_lives),
        .player_1_pos(player_1_pos), .player_2_pos(player_2_pos),
        .resume(resume), .time_up(time_up), .seconds_left(seconds_left), .winner(winner)
    );

    always #5 clk = ~clk;

    // Reference model: phases timed by cycles since entry, doors from a bit-level LFSR.
    task automatic model_reset();
        m_phase = PH_IDLE; m_cyc = 0; m_l1 = 3; m_l2 = 3; m_p1 = 0; m_p2 = 0;
        m_d1 = 0; m_d2 = 1; m_win = 0; m_lfsr = SEED; m_entry = 0;
    endtask

    task automatic enter_round(input logic [15:0] v);
        m_phase = PH_ROUND; m_cyc = 0; m_p1 = 0; m_p2 = 0; m_entry = cycnum;
        m_d1 = int'(v & 16'd3);
        m_d2 = int'((v >> 2) & 16'd3);
        if (m_d2 == m_d1) m_d2 = (m_d1 + 1) % 4;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        cur = m_lfsr;
        m_lfsr = {^(cur & 16'h002D), cur[15:1]};
        m_cyc++;
        case (m_phase)
            PH_IDLE, PH_OVER: if (start) begin
                m_l1 = 3; m_l2 = 3; m_win = 0; enter_round(cur);
            end
            PH_ROUND: if (m_cyc == ROUND_S * CLK_HZ) begin
                if (m_p1 != m_d1 && m_p1 != m_d2 && m_l1 > 0) m_l1--;
                if (m_p2 != m_d1 && m_p2 != m_d2 && m_l2 > 0) m_l2--;
                m_phase = PH_REVEAL; m_cyc = 0;
            end else begin
                if (p1_left && !p1_right && m_p1 > 0) m_p1--;
                if (p1_right && !p1_left && m_p1 < 3) m_p1++;
                if (p2_left && !p2_right && m_p2 > 0) m_p2--;
                if (p2_right && !p2_left && m_p2 < 3) m_p2++;
            end
            PH_REVEAL: if (m_cyc == REVEAL_S * CLK_HZ) begin
                if (m_l1 == 0 || m_l2 == 0) begin
                    m_phase = PH_OVER; m_cyc = 0;
                    m_win = (m_l1 == 0 ? 2 : 0) + (m_l2 == 0 ? 1 : 0);
                end else begin
                    enter_round(cur);
                end
            end
            default: ;
        endcase
    endtask

    function automatic int m_sec();
        case (m_phase)
            PH_IDLE:   return ROUND_S;
            PH_ROUND:  return ROUND_S - m_cyc / CLK_HZ;
            PH_REVEAL: return (m_cyc == 0) ? 0 : REVEAL_S - m_cyc / CLK_HZ;
            default:   return 0;
        endcase
    endfunction

    function automatic int wrong_door();
        for (int d = 0; d < 4; d++) if (d != m_d1 && d != m_d2) return d;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        cycnum++;
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic drive_to(input int t1, input int t2);
        for (int i = 0; i < 4; i++) begin
            p1_right = (m_p1 < t1); p1_left = (m_p1 > t1);
            p2_right = (m_p2 < t2); p2_left = (m_p2 > t2);
            step();
            p1_right = 1'b0; p1_left = 1'b0; p2_right = 1'b0; p2_left = 1'b0;
        end
    endtask

    task automatic play_round(input bit p1_bad, input bit p2_bad);
        drive_to(p1_bad ? wrong_door() : m_d1, p2_bad ? wrong_door() : m_d1);
        for (int i = 0; i < 60 && m_phase == PH_ROUND; i++) step();
        for (int i = 0; i < 30 && m_phase == PH_REVEAL; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (p1_lives !== 2'd3) begin n_fail++; $display("FAIL reset_p1_lives got=%0d exp=3", p1_lives); end
        n_checks++; if (p2_lives !== 2'd3) begin n_fail++; $display("FAIL reset_p2_lives got=%0d exp=3", p2_lives); end
        n_checks++; if ({player_1_pos, player_2_pos} !== 4'h0) begin n_fail++; $display("FAIL reset_pos got=%0d/%0d exp=0/0", player_1_pos, player_2_pos); end
        n_checks++; if ({correct_door_1, correct_door_2} !== 4'b0001) begin n_fail++; $display("FAIL reset_doors got=%0d/%0d exp=0/1", correct_door_1, correct_door_2); end
        n_checks++; if ({resume, time_up} !== 2'b10) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=10", resume, time_up); end
        n_checks++; if (winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner got=%b exp=00", winner); end
        n_checks++; if (seconds_left !== 4'(ROUND_S)) begin n_fail++; $display("FAIL reset_seconds got=%0d exp=%0d", seconds_left, ROUND_S); end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (correct_door_1 !== 2'(m_d1) || correct_door_2 !== 2'(m_d2)) begin n_fail++; $display("FAIL start_doors got=%0d/%0d exp=%0d/%0d", correct_door_1, correct_door_2, m_d1, m_d2); end
        n_checks++; if ((correct_door_1 != correct_door_2) !== 1'b1) begin n_fail++; $display("FAIL start_doors_distinct got=%0d/%0d exp=distinct", correct_door_1, correct_door_2); end
        n_checks++; if ({resume, time_up} !== 2'b10) begin n_fail++; $display("FAIL start_flags got=%b%b exp=10", resume, time_up); end
    endtask

    task automatic test_moves();
        p1_left = 1'b1; step(); p1_left = 1'b0;
        n_checks++; if (player_1_pos !== 2'd0) begin n_fail++; $display("FAIL move_left_sat got=%0d exp=0", player_1_pos); end
        for (int i = 0; i < 5; i++) begin
            p1_right = 1'b1; p2_right = (i < 2); step(); p1_right = 1'b0; p2_right = 1'b0;
        end
        n_checks++; if (player_1_pos !== 2'd3) begin n_fail++; $display("FAIL move_right_sat got=%0d exp=3", player_1_pos); end
        n_checks++; if (player_2_pos !== 2'd2) begin n_fail++; $display("FAIL move_p2_indep got=%0d exp=2", player_2_pos); end
        p1_left = 1'b1; p1_right = 1'b1; p2_left = 1'b1; step();
        p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0;
        n_checks++; if (player_1_pos !== 2'd3) begin n_fail++; $display("FAIL move_both_dirs got=%0d exp=3", player_1_pos); end
        n_checks++; if (player_2_pos !== 2'd1) begin n_fail++; $display("FAIL move_p2_left got=%0d exp=1", player_2_pos); end
    endtask

    task automatic test_reveal();
        drive_to(m_d1, wrong_door());
        for (int i = 0; i < 40 && cycnum < m_entry + 19; i++) step();
        n_checks++; if (time_up !== 1'b0) begin n_fail++; $display("FAIL reveal_early got=%b exp=0", time_up); end
        step();
        n_checks++; if ({resume, time_up} !== 2'b01) begin n_fail++; $display("FAIL reveal_flags got=%b%b exp=01", resume, time_up); end
        n_checks++; if ({p1_lives, p2_lives} !== 4'b1110) begin n_fail++; $display("FAIL reveal_lives got=%0d/%0d exp=3/2", p1_lives, p2_lives); end
        for (int i = 0; i < 10; i++) step();
        n_checks++; if ({resume, time_up} !== 2'b10) begin n_fail++; $display("FAIL next_round_flags got=%b%b exp=10", resume, time_up); end
        n_checks++; if ({player_1_pos, player_2_pos} !== 4'h0) begin n_fail++; $display("FAIL next_round_pos got=%0d/%0d exp=0/0", player_1_pos, player_2_pos); end
        n_checks++; if (correct_door_1 !== 2'(m_d1) || correct_door_2 !== 2'(m_d2)) begin n_fail++; $display("FAIL next_round_doors got=%0d/%0d exp=%0d/%0d", correct_door_1, correct_door_2, m_d1, m_d2); end
    endtask

    task automatic test_game_over_p2();
        play_round(1'b0, 1'b1);
        play_round(1'b0, 1'b1);
        n_checks++; if ({resume, time_up} !== 2'b01) begin n_fail++; $display("FAIL over_flags got=%b%b exp=01", resume, time_up); end
        n_checks++; if ({p1_lives, p2_lives} !== 4'b1100) begin n_fail++; $display("FAIL over_lives got=%0d/%0d exp=3/0", p1_lives, p2_lives); end
        n_checks++; if (winner !== 2'b01) begin n_fail++; $display("FAIL over_winner_p1 got=%b exp=01", winner); end
        for (int i = 0; i < 15; i++) step();
        n_checks++; if (time_up !== 1'b1) begin n_fail++; $display("FAIL over_stays got=%b exp=1", time_up); end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if ({p1_lives, p2_lives} !== 4'hF) begin n_fail++; $display("FAIL restart_lives got=%0d/%0d exp=3/3", p1_lives, p2_lives); end
        n_checks++; if ({resume, winner} !== 3'b100) begin n_fail++; $display("FAIL restart_state got=%b/%b exp=1/00", resume, winner); end
    endtask

    task automatic test_draw();
        for (int r = 0; r < 3; r++) play_round(1'b1, 1'b1);
        n_checks++; if ({p1_lives, p2_lives} !== 4'h0) begin n_fail++; $display("FAIL draw_lives got=%0d/%0d exp=0/0", p1_lives, p2_lives); end
        n_checks++; if (winner !== 2'b11) begin n_fail++; $display("FAIL draw_winner got=%b exp=11", winner); end
        n_checks++; if (time_up !== 1'b1) begin n_fail++; $display("FAIL draw_time_up got=%b exp=1", time_up); end
    endtask

    task automatic test_async_reset();
        start = 1'b1; step(); start = 1'b0;
        play_round(1'b0, 1'b1);
        drive_to(3, 1);
        for (int i = 0; i < 20 && cycnum < m_entry + 7; i++) step();
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({p1_lives, p2_lives} !== 4'hF) begin n_fail++; $display("FAIL areset_lives got=%0d/%0d exp=3/3", p1_lives, p2_lives); end
        n_checks++; if ({player_1_pos, player_2_pos} !== 4'h0) begin n_fail++; $display("FAIL areset_pos got=%0d/%0d exp=0/0", player_1_pos, player_2_pos); end
        n_checks++; if ({correct_door_1, correct_door_2} !== 4'b0001) begin n_fail++; $display("FAIL areset_doors got=%0d/%0d exp=0/1", correct_door_1, correct_door_2); end
        n_checks++; if ({resume, time_up, winner} !== 4'b1000) begin n_fail++; $display("FAIL areset_flags got=%b%b/%b exp=10/00", resume, time_up, winner); end
        n_checks++; if (seconds_left !== 4'(ROUND_S)) begin n_fail++; $display("FAIL areset_seconds got=%0d exp=%0d", seconds_left, ROUND_S); end
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_door_collision();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (m_lfsr[3:0] == 4'hF) begin found = 1'b1; break; end
            step();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL collision_search got=none exp=lfsr_low_nibble_F"); end
        start = 1'b1; step(); start = 1'b0;
        if (found) begin
            n_checks++; if ({correct_door_1, correct_door_2} !== 4'b1100) begin n_fail++; $display("FAIL collision_doors got=%0d/%0d exp=3/0", correct_door_1, correct_door_2); end
        end
    endtask

    task automatic test_random();
        logic [21:0] got, exp;
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            start    = ($urandom_range(0, 39) == 0);
            p1_left  = ($urandom_range(0, 3) == 0);
            p1_right = ($urandom_range(0, 3) == 0);
            p2_left  = ($urandom_range(0, 3) == 0);
            p2_right = ($urandom_range(0, 3) == 0);
            step();
            got = {correct_door_1, correct_door_2, p1_lives, p2_lives, player_1_pos, player_2_pos,
                   resume, time_up, seconds_left, winner};
            exp = {2'(m_d1), 2'(m_d2), 2'(m_l1), 2'(m_l2), 2'(m_p1), 2'(m_p2),
                   (m_phase == PH_IDLE || m_phase == PH_ROUND),
                   (m_phase == PH_REVEAL || m_phase == PH_OVER), 4'(m_sec()), 2'(m_win)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                if (bad < 10) $display("FAIL random_outputs cyc=%0d got=%h exp=%h", cycnum, got, exp);
                bad++;
            end
        end
        start = 1'b0; p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0; p2_right = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_moves();
        test_reveal();
        test_game_over_p2();
        test_draw();
        test_async_reset();
        test_door_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
